// File: rtl/bcd_counter_2d_pkg.sv
// BCD digit definitions shared by the two-digit counter and its decade cells.
package bcd_counter_2d_pkg;

  localparam int unsigned BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;
  localparam bcd_t BCD_MIN = 4'd0;

  // Nibbles above 9 are forced to 9 so a digit never holds a non-BCD code.
  function automatic bcd_t bcd_clamp(input logic [BCD_W-1:0] v);
    return (v > BCD_MAX) ? BCD_MAX : v;
  endfunction

endpackage

// File: rtl/bcd_counter_2d_digit.sv
// One BCD decade: clear > load > increment/decrement, with combinational carry/borrow out.
module bcd_digit
  import bcd_counter_2d_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  input  logic             ld,
  input  logic [BCD_W-1:0] ld_val,
  output logic [BCD_W-1:0] q,
  output logic             carry,
  output logic             borrow
);

  assign carry  = inc && (q == BCD_MAX);
  assign borrow = dec && (q == BCD_MIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (ld) begin
      q <= bcd_clamp(ld_val);
    end else if (inc) begin
      q <= (q == BCD_MAX) ? BCD_MIN : q + 1'b1;
    end else if (dec) begin
      q <= (q == BCD_MIN) ? BCD_MAX : q - 1'b1;
    end
  end

endmodule

// File: rtl/bcd_counter_2d.sv
// Two-digit BCD up/down counter with tick prescaler, load/clear and wrap pulse.
module bcd_counter_2d
  import bcd_counter_2d_pkg::*;
#(
  parameter int unsigned PRESCALE = 50_000_000,
  parameter bit          WRAP     = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       up_down,
  input  logic       clear,
  input  logic       load,
  input  logic [7:0] load_value,
  output logic [3:0] units,
  output logic [3:0] tens,
  output logic       wrap_pulse,
  output logic       at_limit
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] presc;
  logic          tick;
  logic          sat_hold;
  logic          step;
  logic          u_carry, u_borrow;
  logic          t_carry, t_borrow;

  assign tick     = enable && (presc == LAST);
  assign at_limit = up_down ? ((tens == BCD_MAX) && (units == BCD_MAX))
                            : ((tens == BCD_MIN) && (units == BCD_MIN));

  // In saturating mode a tick at the limit is swallowed before reaching the digits.
  assign sat_hold = tick && at_limit && !WRAP;
  assign step     = tick && !sat_hold;

  bcd_digit u_units (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (step && up_down),
    .dec    (step && !up_down),
    .clr    (clear),
    .ld     (load),
    .ld_val (load_value[3:0]),
    .q      (units),
    .carry  (u_carry),
    .borrow (u_borrow)
  );

  bcd_digit u_tens (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (u_carry),
    .dec    (u_borrow),
    .clr    (clear),
    .ld     (load),
    .ld_val (load_value[7:4]),
    .q      (tens),
    .carry  (t_carry),
    .borrow (t_borrow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (clear || load) begin
      presc <= '0;
    end else if (enable) begin
      presc <= tick ? '0 : presc + 1'b1;
    end
  end

  // A tens carry/borrow out only occurs on a real wrap, since saturation blocks the step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_pulse <= 1'b0;
    end else if (clear || load) begin
      wrap_pulse <= 1'b0;
    end else begin
      wrap_pulse <= t_carry || t_borrow;
    end
  end

endmodule

// File: tb/tb_bcd_counter_2d.sv
// Self-checking bench: directed table, corner sequences and random traffic vs. an integer model.
module tb_bcd_counter_2d;

  localparam int P = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       up_down = 1'b1;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_value = '0;

  logic [3:0] units_w, tens_w, units_s, tens_s;
  logic       pulse_w, limit_w, pulse_s, limit_s;

  int checks = 0;
  int passed = 0;

  // Model: index 0 = wrapping counter, index 1 = saturating counter.
  int mv[2];
  bit mp[2];
  int pc;

  bcd_counter_2d #(.PRESCALE(P), .WRAP(1'b1)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .enable(enable), .up_down(up_down),
    .clear(clear), .load(load), .load_value(load_value),
    .units(units_w), .tens(tens_w), .wrap_pulse(pulse_w), .at_limit(limit_w)
  );

  bcd_counter_2d #(.PRESCALE(P), .WRAP(1'b0)) dut_sat (
    .clk(clk), .rst_n(rst_n), .enable(enable), .up_down(up_down),
    .clear(clear), .load(load), .load_value(load_value),
    .units(units_s), .tens(tens_s), .wrap_pulse(pulse_s), .at_limit(limit_s)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       clr;
    logic       ld;
    logic [7:0] lv;
    logic       en;
    logic       ud;
    int         cyc;
    int         exp_v;
    logic       exp_p;
    int         exp_s;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    mv[0] = 0; mv[1] = 0; mp[0] = 0; mp[1] = 0; pc = 0;
  endtask

  task automatic model_edge();
    bit tick;
    int t, u;
    if (!rst_n) begin
      model_reset();
    end else if (clear) begin
      model_reset();
    end else if (load) begin
      t = load_value[7:4];
      u = load_value[3:0];
      if (t > 9) t = 9;
      if (u > 9) u = 9;
      mv[0] = t * 10 + u; mv[1] = mv[0];
      mp[0] = 0; mp[1] = 0; pc = 0;
    end else begin
      tick = 0;
      if (enable) begin
        if (pc == P - 1) begin pc = 0; tick = 1; end
        else pc++;
      end
      for (int k = 0; k < 2; k++) begin
        mp[k] = 0;
        if (tick) begin
          if (up_down) begin
            if (mv[k] == 99) begin
              if (k == 0) begin mv[k] = 0; mp[k] = 1; end
            end else mv[k]++;
          end else begin
            if (mv[k] == 0) begin
              if (k == 0) begin mv[k] = 99; mp[k] = 1; end
            end else mv[k]--;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    int lim0, lim1;
    lim0 = up_down ? (mv[0] == 99) : (mv[0] == 0);
    lim1 = up_down ? (mv[1] == 99) : (mv[1] == 0);
    chk("wrap.units", units_w, mv[0] % 10);
    chk("wrap.tens", tens_w, mv[0] / 10);
    chk("wrap.pulse", pulse_w, mp[0]);
    chk("wrap.at_limit", limit_w, lim0);
    chk("sat.units", units_s, mv[1] % 10);
    chk("sat.tens", tens_s, mv[1] / 10);
    chk("sat.pulse", pulse_s, mp[1]);
    chk("sat.at_limit", limit_s, lim1);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic set_in(input logic c, input logic l, input logic [7:0] v,
                        input logic e, input logic d);
    clear = c; load = l; load_value = v; enable = e; up_down = d;
  endtask

  initial begin
    model_reset();
    tbl[0]  = '{1'b0, 1'b1, 8'hFC, 1'b0, 1'b1, 1, 99, 1'b0, 99};
    tbl[1]  = '{1'b1, 1'b1, 8'h55, 1'b0, 1'b1, 1, 0, 1'b0, 0};
    tbl[2]  = '{1'b0, 1'b1, 8'h08, 1'b0, 1'b1, 1, 8, 1'b0, 8};
    tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 12, 11, 1'b0, 11};
    tbl[4]  = '{1'b0, 1'b1, 8'h99, 1'b0, 1'b1, 1, 99, 1'b0, 99};
    tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 4, 0, 1'b1, 99};
    tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1, 0, 1'b0, 99};
    tbl[7]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1, 0, 1'b0, 0};
    tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 4, 99, 1'b1, 0};
    tbl[9]  = '{1'b0, 1'b1, 8'h10, 1'b0, 1'b0, 1, 10, 1'b0, 10};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 4, 9, 1'b0, 9};
    tbl[11] = '{1'b0, 1'b1, 8'hA3, 1'b0, 1'b1, 1, 93, 1'b0, 93};

    // Reset state
    #1;
    chk("reset.units", units_w, 0);
    chk("reset.tens", tens_w, 0);
    chk("reset.pulse", pulse_w, 0);
    repeat (2) cycle();
    rst_n = 1'b1;
    cycle();

    foreach (tbl[i]) begin
      set_in(tbl[i].clr, tbl[i].ld, tbl[i].lv, tbl[i].en, tbl[i].ud);
      repeat (tbl[i].cyc) cycle();
      chk($sformatf("tbl%0d.value", i), tens_w * 10 + units_w, tbl[i].exp_v);
      chk($sformatf("tbl%0d.pulse", i), pulse_w, tbl[i].exp_p);
      chk($sformatf("tbl%0d.sat_value", i), tens_s * 10 + units_s, tbl[i].exp_s);
    end

    // Asynchronous reset mid-count at 47
    set_in(1'b0, 1'b1, 8'h47, 1'b0, 1'b1);
    cycle();
    set_in(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    repeat (2) cycle();
    rst_n = 1'b0;
    #1;
    chk("async_rst.units", units_w, 0);
    chk("async_rst.tens", tens_w, 0);
    chk("async_rst.pulse", pulse_w, 0);
    model_reset();
    cycle();
    rst_n = 1'b1;
    repeat (4) cycle();
    chk("post_rst.first_tick", tens_w * 10 + units_w, 1);

    // Load coinciding with a tick: load wins, no count applied
    set_in(1'b0, 1'b1, 8'h40, 1'b0, 1'b1);
    cycle();
    set_in(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    repeat (3) cycle();
    set_in(1'b0, 1'b1, 8'h42, 1'b1, 1'b1);
    cycle();
    chk("load_on_tick.value", tens_w * 10 + units_w, 42);
    load = 1'b0;
    repeat (3) cycle();
    chk("load_on_tick.hold", tens_w * 10 + units_w, 42);
    cycle();
    chk("load_on_tick.next", tens_w * 10 + units_w, 43);

    // Enable freeze mid-period
    set_in(1'b0, 1'b1, 8'h20, 1'b0, 1'b1);
    cycle();
    set_in(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    repeat (2) cycle();
    enable = 1'b0;
    repeat (10) cycle();
    chk("freeze.hold", tens_w * 10 + units_w, 20);
    enable = 1'b1;
    cycle();
    chk("freeze.resume1", tens_w * 10 + units_w, 20);
    cycle();
    chk("freeze.resume2", tens_w * 10 + units_w, 21);

    // Reset asserted in the wrap cycle suppresses the pulse
    set_in(1'b0, 1'b1, 8'h99, 1'b0, 1'b1);
    cycle();
    set_in(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    repeat (3) cycle();
    rst_n = 1'b0;
    model_reset();
    cycle();
    chk("rst_wrap.pulse", pulse_w, 0);
    rst_n = 1'b1;

    // Random traffic against the model
    for (int n = 0; n < 800; n++) begin
      clear = ($urandom_range(0, 59) == 0);
      load  = ($urandom_range(0, 24) == 0);
      case ($urandom_range(0, 3))
        0: load_value = 8'h99;
        1: load_value = 8'h00;
        default: load_value = 8'($urandom);
      endcase
      enable = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) up_down = ~up_down;
      cycle();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
